// File: rtl/text_link_pkg.sv
// rtl/text_link_pkg.sv - shared text link constants and block assembler state encoding
package text_link_pkg;

    localparam int CHARS = 64;
    localparam int CHAR_W = 8;
    localparam int BLOCK_W = CHARS * CHAR_W;
    localparam logic [CHAR_W-1:0] PAD_CHAR = 8'h20;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_PAD     = 2'd1,
        ST_PRESENT = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/text_block_assembler_if.sv
// rtl/text_block_assembler_if.sv - character stream in, 512-bit block out with valid/received handshake
interface text_block_assembler_if;
    import text_link_pkg::*;

    logic              in_valid;
    logic [CHAR_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;
    logic [BLOCK_W-1:0] data_out;
    logic              data_valid;
    logic              data_received;

    // master: the assembler (consumes characters, produces blocks)
    modport master (
        input  in_valid, in_data, in_last, data_received,
        output in_ready, data_out, data_valid
    );

    // slave: the character source and block sink around it
    modport slave (
        output in_valid, in_data, in_last, data_received,
        input  in_ready, data_out, data_valid
    );

endinterface

// File: rtl/text_block_assembler.sv
// rtl/text_block_assembler.sv - packs 64 characters into a block, pads a short final block, hands it to the sink
module text_block_assembler #(
    parameter int CHARS = text_link_pkg::CHARS,
    parameter int CHAR_W = text_link_pkg::CHAR_W,
    parameter logic [CHAR_W-1:0] PAD_CHAR = text_link_pkg::PAD_CHAR
) (
    input  logic                    clk,
    input  logic                    reset,
    text_block_assembler_if.master  blk,
    output logic                    text_done,
    output logic [7:0]              block_count
);
    import text_link_pkg::state_e;
    import text_link_pkg::ST_COLLECT;
    import text_link_pkg::ST_PAD;
    import text_link_pkg::ST_PRESENT;
    import text_link_pkg::ST_DONE;

    localparam int BLOCK_W = CHARS * CHAR_W;
    localparam logic [6:0] LAST_IDX = 7'(CHARS - 1);

    state_e             state_q, state_d;
    logic [6:0]         cnt_q, cnt_d;
    logic [BLOCK_W-1:0] data_q, data_d;
    logic               last_seen_q, last_seen_d;
    logic [7:0]         count_q, count_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_COLLECT;
            cnt_q       <= 7'd0;
            data_q      <= '0;
            last_seen_q <= 1'b0;
            count_q     <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            last_seen_q <= last_seen_d;
            count_q     <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        last_seen_d = last_seen_q;
        count_d     = count_q;
        case (state_q)
            ST_COLLECT: begin
                // in_ready is 1 here, so in_valid alone means an accept
                if (blk.in_valid) begin
                    data_d = {data_q[BLOCK_W-CHAR_W-1:0], blk.in_data};
                    cnt_d  = cnt_q + 7'd1;
                    if (blk.in_last) begin
                        last_seen_d = 1'b1;
                    end
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_PRESENT;
                    end else if (blk.in_last) begin
                        state_d = ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                data_d = {data_q[BLOCK_W-CHAR_W-1:0], PAD_CHAR};
                cnt_d  = cnt_q + 7'd1;
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (blk.data_received) begin
                    cnt_d   = 7'd0;
                    count_d = count_q + 8'd1;
                    state_d = last_seen_q ? ST_DONE : ST_COLLECT;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end

    assign blk.in_ready   = (state_q == ST_COLLECT);
    assign blk.data_valid = (state_q == ST_PRESENT);
    assign blk.data_out   = data_q;
    assign text_done      = (state_q == ST_DONE);
    assign block_count    = count_q;

endmodule

// File: tb/tb_text_block_assembler.sv
// tb/tb_text_block_assembler.sv - directed self-checking bench for text_block_assembler
module tb_text_block_assembler;

    logic       clk;
    logic       reset;
    logic       text_done;
    logic [7:0] block_count;

    text_block_assembler_if bus ();

    text_block_assembler dut (
        .clk         (clk),
        .reset       (reset),
        .blk         (bus),
        .text_done   (text_done),
        .block_count (block_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [511:0] exp_blk;

    task automatic send_char(input logic [7:0] c, input logic last);
        bus.in_valid = 1'b1;
        bus.in_data  = c;
        bus.in_last  = last;
        @(negedge clk);
        bus.in_last  = 1'b0;
    endtask

    task automatic ack();
        bus.data_received = 1'b1;
        @(negedge clk);
        bus.data_received = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (bus.data_out !== 512'd0 || bus.data_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
            text_done !== 1'b0 || block_count !== 8'd0) begin
            errors++;
            $display("FAIL %s: data_out_hi=%h valid=%b ready=%b done=%b count=%0d, required 0/0/1/0/0",
                     tag, bus.data_out[511:448], bus.data_valid, bus.in_ready, text_done, block_count);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_reset_values("reset_state");
        reset = 1'b0;
        @(negedge clk);
        check_reset_values("after_reset_release");
    endtask

    task automatic test_full_block_and_ack();
        exp_blk = '0;
        for (int i = 0; i < 64; i++) begin
            exp_blk = {exp_blk[503:0], 8'(i)};
            send_char(8'(i), 1'b0);
        end
        // keep offering characters while the block is presented
        bus.in_data = 8'hFF;
        checks++;
        if (bus.data_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_valid_latency: valid=%b ready=%b, required 1/0", bus.data_valid, bus.in_ready);
        end
        checks++;
        if (bus.data_out[511:504] !== 8'h00 || bus.data_out[7:0] !== 8'h3F) begin
            errors++;
            $display("FAIL full_ends: first=%h last=%h, required 00/3f", bus.data_out[511:504], bus.data_out[7:0]);
        end
        checks++;
        if (bus.data_out !== exp_blk) begin
            errors++;
            $display("FAIL full_block: got %h, required %h", bus.data_out, exp_blk);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (bus.data_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.data_out !== exp_blk) begin
                errors++;
                $display("FAIL present_hold cycle %0d: valid=%b ready=%b, required 1/0 and frozen block",
                         c, bus.data_valid, bus.in_ready);
            end
        end
        bus.data_received = 1'b1;
        @(negedge clk);
        bus.data_received = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.data_valid !== 1'b0 || bus.in_ready !== 1'b1 || block_count !== 8'd1 || text_done !== 1'b0) begin
            errors++;
            $display("FAIL ack: valid=%b ready=%b count=%0d done=%b, required 0/1/1/0",
                     bus.data_valid, bus.in_ready, block_count, text_done);
        end
    endtask

    task automatic test_spurious_ack_and_second_block();
        ack();
        @(negedge clk);
        checks++;
        if (block_count !== 8'd1 || bus.data_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL spurious_ack: count=%0d valid=%b ready=%b, required 1/0/1",
                     block_count, bus.data_valid, bus.in_ready);
        end
        for (int i = 0; i < 64; i++) begin
            exp_blk = {exp_blk[503:0], 8'(8'h80 + i)};
            send_char(8'(8'h80 + i), 1'b0);
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bus.data_valid !== 1'b1 || bus.data_out !== exp_blk || bus.data_out[511:504] !== 8'h80) begin
            errors++;
            $display("FAIL second_block: valid=%b got %h, required %h", bus.data_valid, bus.data_out, exp_blk);
        end
        ack();
        checks++;
        if (block_count !== 8'd2 || text_done !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL second_ack: count=%0d done=%b ready=%b, required 2/0/1",
                     block_count, text_done, bus.in_ready);
        end
    endtask

    task automatic test_reset_mid_block();
        for (int i = 0; i < 30; i++) begin
            send_char(8'(8'hA0 + i), 1'b0);
        end
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("reset_mid_block");
        reset = 1'b0;
        @(negedge clk);
        exp_blk = '0;
        for (int i = 0; i < 64; i++) begin
            exp_blk = {exp_blk[503:0], 8'(i * 3 + 1)};
            send_char(8'(i * 3 + 1), 1'b0);
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bus.data_valid !== 1'b1 || bus.data_out !== exp_blk || bus.data_out[511:504] !== 8'h01) begin
            errors++;
            $display("FAIL clean_block_after_reset: valid=%b got %h, required %h",
                     bus.data_valid, bus.data_out, exp_blk);
        end
        ack();
        checks++;
        if (block_count !== 8'd1) begin
            errors++;
            $display("FAIL count_after_reset: got %0d, required 1", block_count);
        end
    endtask

    task automatic test_exact_fit();
        for (int i = 0; i < 64; i++) begin
            exp_blk = {exp_blk[503:0], 8'(8'h10 + i)};
            send_char(8'(8'h10 + i), (i == 63));
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bus.data_valid !== 1'b1 || bus.data_out !== exp_blk) begin
            errors++;
            $display("FAIL exact_fit_no_pad: valid=%b got %h, required valid=1 and %h",
                     bus.data_valid, bus.data_out, exp_blk);
        end
        ack();
        checks++;
        if (text_done !== 1'b1 || bus.in_ready !== 1'b0 || bus.data_valid !== 1'b0 || block_count !== 8'd2) begin
            errors++;
            $display("FAIL exact_fit_done: done=%b ready=%b valid=%b count=%0d, required 1/0/0/2",
                     text_done, bus.in_ready, bus.data_valid, block_count);
        end
    endtask

    task automatic test_partial_last_block();
        int pad_cycles;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send_char(8'h41, 1'b0);
        send_char(8'h42, 1'b0);
        send_char(8'h43, 1'b1);
        // characters offered during padding must be ignored
        bus.in_data = 8'hEE;
        pad_cycles = 0;
        while (bus.data_valid !== 1'b1 && pad_cycles < 200) begin
            if (bus.in_ready !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL pad_ready at pad cycle %0d: got %b, required 0", pad_cycles, bus.in_ready);
            end
            @(negedge clk);
            pad_cycles++;
        end
        checks++;
        if (pad_cycles !== 61) begin
            errors++;
            $display("FAIL pad_cycles: got %0d, required 61", pad_cycles);
        end
        exp_blk = {8'h41, 8'h42, 8'h43, {61{8'h20}}};
        checks++;
        if (bus.data_out !== exp_blk) begin
            errors++;
            $display("FAIL partial_block: got %h, required %h", bus.data_out, exp_blk);
        end
        ack();
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (text_done !== 1'b1 || bus.in_ready !== 1'b0 || bus.data_valid !== 1'b0 || block_count !== 8'd1) begin
                errors++;
                $display("FAIL partial_done cycle %0d: done=%b ready=%b valid=%b count=%0d, required 1/0/0/1",
                         c, text_done, bus.in_ready, bus.data_valid, block_count);
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        reset             = 1'b1;
        bus.in_valid      = 1'b0;
        bus.in_data       = 8'h00;
        bus.in_last       = 1'b0;
        bus.data_received = 1'b0;
        test_reset();
        test_full_block_and_ack();
        test_spurious_ack_and_second_block();
        test_reset_mid_block();
        test_exact_fit();
        test_partial_last_block();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
